// File: rtl/ssd_scan_if.sv
// Seven-segment scan controller bus: caller-side inputs and board-side pin outputs.
interface ssd_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    enable;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              cathode;
    logic                    dp;
    logic                    busy;

    modport master (
        output value_in, load, dp_in, blank_lz, enable,
        input  anode, cathode, dp, busy
    );

    modport slave (
        input  value_in, load, dp_in, blank_lz, enable,
        output anode, cathode, dp, busy
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller with value latch, leading-zero blanking and per-digit DP.
// Define SSD_BIN2BCD_EN to accept unsigned binary on value_in[BIN_W-1:0]; a double-dabble
// converter then fills the display register, showing '-' on every digit when out of range.
module ssd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BIN_W      = 16
) (
    input logic       board_clk,
    input logic       reset,
    ssd_scan_if.slave bus
);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]        prescaler_q;
    logic [IDX_W-1:0]        digit_idx_q;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    ovf;
    logic                    busy;
    logic [NUM_DIGITS-1:0]   lz_zero;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic                    dp_q, dp_d;
    logic [3:0]              nibble;
    logic                    blank_digit;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick = (prescaler_q == PRE_W'(SCAN_DIV - 1));

    // Free-running scan counters; independent of enable so the position is kept while dark.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
        end else if (tick) begin
            prescaler_q <= '0;
            digit_idx_q <= (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
        end else begin
            prescaler_q <= prescaler_q + 1'b1;
        end
    end

    // Display register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

`ifdef SSD_BIN2BCD_EN
    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

    // Digits above NUM_DIGITS in the 8-digit BCD result flag an out-of-range value.
    localparam logic [31:0] HI_MASK = 32'(~((64'd1 << (4 * NUM_DIGITS)) - 64'd1));

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d, bcd_adj;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      val_ext;
    logic             ovf_q, ovf_d;

    assign val_ext = 32'(bus.value_in);

    // Converter state register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Add-3 correction on every BCD digit ahead of the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 8; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Double-dabble sequencing; a new load always restarts from scratch.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        if (bus.load) begin
            state_d = StShift;
            bin_d   = val_ext[BIN_W-1:0];
            bcd_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StShift: begin
                    bcd_d = {bcd_adj[30:0], bin_q[BIN_W-1]};
                    bin_d = bin_q << 1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(BIN_W - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    disp_d  = bcd_q[4*NUM_DIGITS-1:0];
                    ovf_d   = |(bcd_q & HI_MASK);
                    state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign ovf  = ovf_q;
`else
    logic busy_q;

    // BIN_W has no effect in the hex build.
    if (BIN_W == 0) begin : g_bin_w_ignored
    end

    // Hex capture path.
    always_comb begin
        disp_d = bus.load ? bus.value_in : disp_q;
    end

    // Busy flags the single cycle in which the new value lands.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= bus.load;
        end
    end

    assign busy = busy_q;
    assign ovf  = 1'b0;
`endif

    // lz_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        lz_run  = 1'b1;
        lz_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run & (disp_q[4*i +: 4] == 4'h0);
            lz_zero[i] = lz_run;
        end
    end

    // Next pin values for the currently selected digit.
    always_comb begin
        nibble      = disp_q[4*digit_idx_q +: 4];
        blank_digit = bus.blank_lz && (digit_idx_q != '0) && lz_zero[digit_idx_q];
        anode_d     = '1;
        cathode_d   = 7'h7F;
        dp_d        = 1'b1;
        if (bus.enable) begin
            anode_d = ~(NUM_DIGITS'(1) << digit_idx_q);
            dp_d    = ~bus.dp_in[digit_idx_q];
            if (ovf) begin
                cathode_d = 7'b1111110;
            end else if (blank_digit) begin
                cathode_d = 7'h7F;
            end else begin
                cathode_d = seg7(nibble);
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            anode_q   <= '1;
            cathode_q <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;
    assign bus.dp      = dp_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BIN_W=16).
// Honours SSD_BIN2BCD_EN the same way as the design.
module tb_ssd_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BW = 16;
`ifdef SSD_BIN2BCD_EN
    localparam int BUSY_LEN = BW + 1;
`else
    localparam int BUSY_LEN = 1;
`endif

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic board_clk = 1'b0;
    logic reset     = 1'b0;
    always #5 board_clk = ~board_clk;

    ssd_scan_if #(.NUM_DIGITS(ND)) bus ();

    ssd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BIN_W(BW)) dut (
        .board_clk(board_clk),
        .reset    (reset),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: scan position derived from elapsed cycles, display content as a value.
    int unsigned ncyc;
    logic [15:0] disp_m;
    logic        ovf_m;
    int          pend;
    logic [15:0] pend_val;

    typedef struct {
        logic [15:0] val;
        logic        blank;
        logic [3:0]  dpr;
        int          digit;
        logic [6:0]  ca;
        logic        dpo;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bcd_model(input logic [15:0] v, output logic [15:0] d, output logic o);
        int unsigned x;
        x = v;
        d = '0;
        o = (x >= 10000);
        for (int k = 0; k < 4; k++) begin
            d[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endtask

    // One clock: drive load/value, predict registered outputs, compare just after the edge.
    task automatic step(input logic ld, input logic [15:0] val);
        int          idx;
        logic [3:0]  exp_an;
        logic [6:0]  exp_ca;
        logic        exp_dp;
        logic        exp_busy;
        logic [15:0] upper;
        bus.load     = ld;
        bus.value_in = val;
        idx = int'((ncyc / SD) % ND);
        if (!bus.enable) begin
            exp_an = 4'hF;
            exp_ca = 7'h7F;
            exp_dp = 1'b1;
        end else begin
            exp_an = ~(4'b0001 << idx);
            upper  = disp_m >> (4 * idx);
            if (ovf_m) exp_ca = 7'b1111110;
            else if (bus.blank_lz && idx > 0 && upper == 16'h0) exp_ca = 7'h7F;
            else exp_ca = SEG[upper[3:0]];
            exp_dp = ~bus.dp_in[idx];
        end
        @(posedge board_clk);
        ncyc++;
`ifdef SSD_BIN2BCD_EN
        if (ld) begin
            pend     = BW + 1;
            pend_val = val;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) bcd_model(pend_val, disp_m, ovf_m);
        end
        exp_busy = (pend > 0);
`else
        if (ld) disp_m = val;
        exp_busy = ld;
`endif
        #1;
        chk("anode", 32'(bus.anode), 32'(exp_an));
        chk("cathode", 32'(bus.cathode), 32'(exp_ca));
        chk("dp", 32'(bus.dp), 32'(exp_dp));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        bus.load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_anode", 32'(bus.anode), 32'hF);
        chk("rst_cathode", 32'(bus.cathode), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge board_clk);
        #1;
        chk("rst_hold_anode", 32'(bus.anode), 32'hF);
        reset  = 1'b0;
        ncyc   = 0;
        disp_m = '0;
        ovf_m  = 1'b0;
        pend   = 0;
    endtask

    initial begin
        logic [3:0] tgt;
        logic       found;
        int         n;

        bus.value_in = '0;
        bus.load     = 1'b0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        bus.enable   = 1'b1;
        #2;
        do_reset();

        // Anode rotation straight after reset release, then load timing.
        repeat (20) step(1'b0, 16'h0);

        // Vector table: load, let it settle, then inspect one digit slot.
`ifdef SSD_BIN2BCD_EN
        vecs.push_back('{16'd1234, 1'b0, 4'b0000, 0, 7'b1001100, 1'b1});
        vecs.push_back('{16'd1234, 1'b0, 4'b0000, 1, 7'b0000110, 1'b1});
        vecs.push_back('{16'd1234, 1'b0, 4'b0000, 2, 7'b0010010, 1'b1});
        vecs.push_back('{16'd1234, 1'b0, 4'b0000, 3, 7'b1001111, 1'b1});
        vecs.push_back('{16'd12345, 1'b1, 4'b0000, 3, 7'b1111110, 1'b1});
        vecs.push_back('{16'd12345, 1'b1, 4'b0000, 0, 7'b1111110, 1'b1});
        vecs.push_back('{16'd5, 1'b1, 4'b0000, 3, 7'h7F, 1'b1});
        vecs.push_back('{16'd5, 1'b1, 4'b0000, 0, 7'b0100100, 1'b1});
        vecs.push_back('{16'd0, 1'b1, 4'b0000, 0, 7'b0000001, 1'b1});
        vecs.push_back('{16'd1234, 1'b0, 4'b0100, 2, 7'b0010010, 1'b0});
`else
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 0, 7'b0111000, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 1, 7'b0001000, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 2, 7'b0010010, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 3, 7'b1001111, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 3, 7'h7F, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 1, 7'h7F, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 0, 7'b0100100, 1'b1});
        vecs.push_back('{16'h0000, 1'b1, 4'b0000, 0, 7'b0000001, 1'b1});
        vecs.push_back('{16'h0005, 1'b0, 4'b0000, 3, 7'b0000001, 1'b1});
        vecs.push_back('{16'h0500, 1'b1, 4'b0000, 1, 7'b0000001, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0100, 2, 7'b0010010, 1'b0});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0100, 1, 7'b0001000, 1'b1});
`endif
        foreach (vecs[v]) begin
            bus.blank_lz = vecs[v].blank;
            bus.dp_in    = vecs[v].dpr;
            step(1'b1, vecs[v].val);
            repeat (20) step(1'b0, 16'h0);
            tgt   = ~(4'b0001 << vecs[v].digit);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                step(1'b0, 16'h0);
                if (bus.anode == tgt) found = 1'b1;
            end
            chk($sformatf("vec%0d_found", v), 32'(found), 32'h1);
            chk($sformatf("vec%0d_cathode", v), 32'(bus.cathode), 32'(vecs[v].ca));
            chk($sformatf("vec%0d_dp", v), 32'(bus.dp), 32'(vecs[v].dpo));
        end
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;

        // Enable drop at digit 2: dark next cycle, resumes at the running scan position.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 16'h0);
            if (bus.anode == 4'b1011) found = 1'b1;
        end
        chk("en_find_digit2", 32'(found), 32'h1);
        bus.enable = 1'b0;
        step(1'b0, 16'h0);
        chk("en_dark", 32'(bus.anode), 32'hF);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        bus.enable = 1'b1;
        step(1'b0, 16'h0);
        chk("en_resume", 32'(bus.anode == 4'b1011 || bus.anode == 4'b0111), 32'h1);

        // Busy length, including a reload while a load is still being processed.
        step(1'b1, 16'h1234);
        repeat (3) step(1'b0, 16'h0);
        n = 0;
        step(1'b1, 16'd42);
        for (int i = 0; i < 40 && bus.busy; i++) begin
            n++;
            step(1'b0, 16'h0);
        end
        chk("busy_len", 32'(n), 32'(BUSY_LEN));
        repeat (20) step(1'b0, 16'h0);

        // Randomised traffic checked against the model every cycle, with a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.blank_lz = 1'($urandom);
            bus.dp_in    = 4'($urandom);
            if (i == 300) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) step(1'b1, 16'($urandom_range(0, 12000)));
                else step(1'b1, 16'($urandom) & 16'h00FF);
            end else begin
                step(1'b0, 16'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
